// File: rtl/sine_pkg.sv
// Shared constants and state type for the sine generator and its sweep sequencer.
package sine_pkg;

  // Signed phase width; fixed point with 1.0 = 2^(RADIAN_WIDTH-3).
  localparam int unsigned RADIAN_WIDTH = 28;

  localparam int FACTOR_1  = 33554432;   // 2^25
  localparam int PI        = 105414357;
  localparam int PI_OVER_2 = 52707179;
  localparam int PI_X_2    = 210828714;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } sweep_state_e;

endpackage

// File: rtl/sat_add_sym.sv
// Signed add clamped symmetrically to +/-BOUND; the sum is formed one bit wider so
// it can never wrap before the clamp.
module sat_add_sym #(
  parameter int unsigned WIDTH = 28,
  parameter int          BOUND = 105414357
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum
);

  localparam logic signed [WIDTH:0] BoundPos = (WIDTH+1)'(BOUND);
  localparam logic signed [WIDTH:0] BoundNeg = -BoundPos;

  logic signed [WIDTH:0] wide;

  // Widened add followed by clamp to the symmetric bound.
  always_comb begin
    wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (wide > BoundPos) begin
      sum = BoundPos[WIDTH-1:0];
    end else if (wide < BoundNeg) begin
      sum = BoundNeg[WIDTH-1:0];
    end else begin
      sum = wide[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Per-channel phase-step sequencer feeding the CORDIC sine generator. Each sample
// tick issues one step per channel in order; each accepted step is then swept by
// that channel's signed delta with saturation.
module sine_sweep_ctrl #(
  parameter int unsigned NR_CHANNELS   = 3,
  parameter int unsigned CHANNEL_WIDTH = $clog2(NR_CHANNELS),
  parameter int unsigned RADIAN_WIDTH  = sine_pkg::RADIAN_WIDTH,
  parameter int          STEP_MAX      = sine_pkg::PI
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic        [CHANNEL_WIDTH-1:0] cfg_ch,
  input  logic signed [RADIAN_WIDTH-1:0]  cfg_step,
  input  logic signed [RADIAN_WIDTH-1:0]  cfg_delta,
  input  logic                            cfg_zero,
  input  logic                            cfg_wr,
  input  logic                            s_tick,
  output logic signed [RADIAN_WIDTH-1:0]  m_sine_d,
  output logic        [CHANNEL_WIDTH-1:0] m_sine_ch,
  output logic                            m_sine_zero,
  output logic                            m_sine_dv,
  input  logic                            m_sine_dr,
  output logic                            busy,
  output logic                            overrun
);

  import sine_pkg::*;

  localparam logic [CHANNEL_WIDTH-1:0] LastCh = CHANNEL_WIDTH'(NR_CHANNELS - 1);

  sweep_state_e state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] cur_ch_q, cur_ch_d;

  logic signed [RADIAN_WIDTH-1:0] step_q  [NR_CHANNELS];
  logic signed [RADIAN_WIDTH-1:0] delta_q [NR_CHANNELS];
  logic        [NR_CHANNELS-1:0]  zero_pend_q;

  logic signed [RADIAN_WIDTH-1:0] m_d_q;
  logic        [CHANNEL_WIDTH-1:0] m_ch_q;
  logic                           m_zero_q;
  logic                           m_dv_q;
  logic                           overrun_q;

  logic                           xfer;
  logic signed [RADIAN_WIDTH-1:0] step_next;

  assign xfer = m_dv_q && m_sine_dr;

  sat_add_sym #(
    .WIDTH (RADIAN_WIDTH),
    .BOUND (STEP_MAX)
  ) u_sat (
    .a   (step_q[cur_ch_q]),
    .b   (delta_q[cur_ch_q]),
    .sum (step_next)
  );

  // Next-state logic for the issue sequencer.
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    unique case (state_q)
      StIdle: begin
        if (s_tick) begin
          cur_ch_d = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (xfer) begin
          if (cur_ch_q == LastCh) begin
            state_d = StIdle;
          end else begin
            cur_ch_d = cur_ch_q + 1'b1;
            state_d  = StIssue;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state, sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_ch_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      // Any tick outside IDLE is lost, including one coinciding with the last transfer.
      if (s_tick && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Output register: loaded in ISSUE, held through WAIT until the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_d_q    <= '0;
      m_ch_q   <= '0;
      m_zero_q <= 1'b0;
      m_dv_q   <= 1'b0;
    end else if (state_q == StIssue) begin
      m_d_q    <= step_q[cur_ch_q];
      m_ch_q   <= cur_ch_q;
      m_zero_q <= zero_pend_q[cur_ch_q];
      m_dv_q   <= 1'b1;
    end else if (xfer) begin
      m_dv_q <= 1'b0;
    end
  end

  // Per-channel config; a config write beats the sweep update on the same channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_CHANNELS; i++) begin
        step_q[i]  <= '0;
        delta_q[i] <= '0;
      end
      zero_pend_q <= '0;
    end else begin
      for (int i = 0; i < NR_CHANNELS; i++) begin
        if (cfg_wr && (cfg_ch == CHANNEL_WIDTH'(i))) begin
          step_q[i]      <= cfg_step;
          delta_q[i]     <= cfg_delta;
          zero_pend_q[i] <= zero_pend_q[i] | cfg_zero;
        end else if (xfer && (cur_ch_q == CHANNEL_WIDTH'(i))) begin
          step_q[i]      <= step_next;
          zero_pend_q[i] <= 1'b0;
        end
      end
    end
  end

  assign m_sine_d    = m_d_q;
  assign m_sine_ch   = m_ch_q;
  assign m_sine_zero = m_zero_q;
  assign m_sine_dv   = m_dv_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;

endmodule
